sobel_window_ctrl: RTL and testbench

Sequencer for the 3×3 Sobel line-buffer datapath. It counts incoming pixels into column and row positions and drives the row-RAM write enables, the write and read addresses, and the column shift enable. It flags when the 3×3 window is fully populated and reports the window-centre coordinates. It sits between the camera pixel stream and the row-RAM/shift-register array, replacing the free-running column decode with frame-aware sequencing.

---
 rtl/sobel_pkg.sv | 33 +++
 rtl/sobel_window_ctrl_if.sv | 53 +++++
 rtl/sobel_pos_cnt.sv | 71 +++++++
 rtl/sobel_window_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: definitions shared by the Sobel window sequencer and the edge datapath.
//   - state_e    : frame sequencing states (WAIT_SOF, PRIME, STREAM)
//   - LINE_W_DEF : default pixels per line
//   - FRAME_H_DEF: default lines per frame
//   - ADR_W_DEF  : default row-RAM address width
//   - COORD_W    : window-centre coordinate width, also used by the edge datapath
//   - on_edge()  : true when a window centre sits on the outermost valid ring
package sobel_pkg;

    localparam int LINE_W_DEF  = 640;
    localparam int FRAME_H_DEF = 480;
    localparam int ADR_W_DEF   = 10;
    localparam int COORD_W     = 13;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PRIME    = 2'd1,
        STREAM   = 2'd2
    } state_e;

    // A centre is on the frame edge when it is the first or last centre a full
    // 3x3 window can reach in either direction.
    function automatic logic on_edge(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int                 line_w,
        input int                 frame_h
    );
        return (x == COORD_W'(1)) || (x == COORD_W'(line_w - 2)) ||
               (y == COORD_W'(1)) || (y == COORD_W'(frame_h - 2));
    endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// sobel_window_ctrl_if: pixel-stream control in, line-buffer sequencing out.
//   sof, pix_valid               : from the camera stream (master drives)
//   shift_en, wr_en, wr_adr,
//   rd_adr                       : row-RAM / shift-register control
//   win_valid, x_out, y_out      : window status and centre coordinates
//   line_done, frame_done        : end-of-line / end-of-frame pulses
//   border                       : only when SOBEL_BORDER_EN is defined
interface sobel_window_ctrl_if
    import sobel_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF
) ();

    logic               sof;
    logic               pix_valid;
    logic               shift_en;
    logic [2:0]         wr_en;
    logic [ADR_W-1:0]   wr_adr;
    logic [ADR_W-1:0]   rd_adr;
    logic               win_valid;
    logic [COORD_W-1:0] x_out;
    logic [COORD_W-1:0] y_out;
    logic               line_done;
    logic               frame_done;
`ifdef SOBEL_BORDER_EN
    logic               border;

    modport master (
        output sof, pix_valid,
        input  shift_en, wr_en, wr_adr, rd_adr, win_valid, x_out, y_out,
               line_done, frame_done, border
    );

    modport slave (
        input  sof, pix_valid,
        output shift_en, wr_en, wr_adr, rd_adr, win_valid, x_out, y_out,
               line_done, frame_done, border
    );
`else
    modport master (
        output sof, pix_valid,
        input  shift_en, wr_en, wr_adr, rd_adr, win_valid, x_out, y_out,
               line_done, frame_done
    );

    modport slave (
        input  sof, pix_valid,
        output shift_en, wr_en, wr_adr, rd_adr, win_valid, x_out, y_out,
               line_done, frame_done
    );
`endif

endinterface

// File: rtl/sobel_pos_cnt.sv
// sobel_pos_cnt: column/row position counters for the Sobel sequencer.
//   clk, rst      : pixel clock, synchronous active-high reset
//   restart       : frame start accepted this cycle; the pixel is counted as (0,0)
//   advance       : pixel accepted inside an active frame
//   pix_col_s     : column of the pixel accepted this cycle
//   pix_row_s     : row of the pixel accepted this cycle
//   line_end_s    : accepted pixel is the last of its line (never on a restart)
//   frame_end_s   : accepted pixel is the last of the frame (never on a restart)
module sobel_pos_cnt
    import sobel_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int ADR_W   = ADR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               advance,
    output logic [ADR_W-1:0]   pix_col_s,
    output logic [COORD_W-1:0] pix_row_s,
    output logic               line_end_s,
    output logic               frame_end_s
);

    logic [ADR_W-1:0]   col_r;
    logic [COORD_W-1:0] row_r;
    logic               step_s;
    logic               last_col_s;
    logic               last_row_s;

    // Position of the accepted pixel; a frame start overrides the running count.
    always_comb begin
        step_s = restart | advance;
        if (restart) begin
            pix_col_s = {ADR_W{1'b0}};
            pix_row_s = {COORD_W{1'b0}};
        end else begin
            pix_col_s = col_r;
            pix_row_s = row_r;
        end
        last_col_s  = (pix_col_s == ADR_W'(LINE_W - 1));
        last_row_s  = (pix_row_s == COORD_W'(FRAME_H - 1));
        line_end_s  = advance & ~restart & last_col_s;
        frame_end_s = line_end_s & last_row_s;
    end

    // Counters point at the next pixel; wrap the column per line and the row per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= {ADR_W{1'b0}};
            row_r <= {COORD_W{1'b0}};
        end else if (step_s) begin
            if (last_col_s) begin
                col_r <= {ADR_W{1'b0}};
                if (last_row_s) begin
                    row_r <= {COORD_W{1'b0}};
                end else begin
                    row_r <= pix_row_s + COORD_W'(1);
                end
            end else begin
                col_r <= pix_col_s + ADR_W'(1);
                row_r <= pix_row_s;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: frame-aware sequencer for the 3x3 Sobel line-buffer datapath.
//   clk, rst : pixel clock, synchronous active-high reset
//   bus      : sobel_window_ctrl_if.slave
//              in : sof, pix_valid
//              out: shift_en, wr_en[2:0], wr_adr, rd_adr, win_valid, x_out,
//                   y_out, line_done, frame_done (+ border)
// Optional feature macro: SOBEL_BORDER_EN adds the registered border flag.
// Every output reflects the pixel accepted on the previous clock.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int ADR_W   = ADR_W_DEF
) (
    input  logic clk,
    input  logic rst,
    sobel_window_ctrl_if.slave bus
);

    state_e             state_r;
    logic [2:0]         wr_en_r;
    logic               shift_en_r;
    logic [ADR_W-1:0]   wr_adr_r;
    logic [ADR_W-1:0]   rd_adr_r;
    logic               win_valid_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic               line_done_r;
    logic               frame_done_r;

    logic               restart_s;
    logic               advance_s;
    logic               take_s;
    logic [ADR_W-1:0]   pix_col_s;
    logic [COORD_W-1:0] pix_row_s;
    logic               line_end_s;
    logic               frame_end_s;
    logic               row_ge1_s;
    logic               row_ge2_s;
    logic               win_s;
    logic [ADR_W-1:0]   rd_next_s;
    logic [COORD_W-1:0] x_next_s;
    logic [COORD_W-1:0] y_next_s;

    sobel_pos_cnt #(
        .LINE_W  (LINE_W),
        .FRAME_H (FRAME_H),
        .ADR_W   (ADR_W)
    ) u_pos_cnt (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart_s),
        .advance     (advance_s),
        .pix_col_s   (pix_col_s),
        .pix_row_s   (pix_row_s),
        .line_end_s  (line_end_s),
        .frame_end_s (frame_end_s)
    );

    // Pixel acceptance and per-pixel decode of enables, addresses and window centre.
    always_comb begin
        restart_s = bus.sof & bus.pix_valid;
        advance_s = bus.pix_valid & (state_r != WAIT_SOF);
        take_s    = restart_s | advance_s;
        row_ge1_s = (pix_row_s >= COORD_W'(1));
        row_ge2_s = (pix_row_s >= COORD_W'(2));
        // Two columns of history are needed before the window is full.
        win_s     = take_s & row_ge2_s & (pix_col_s >= ADR_W'(2));
        if (pix_col_s == ADR_W'(LINE_W - 1)) begin
            rd_next_s = {ADR_W{1'b0}};
        end else begin
            rd_next_s = pix_col_s + ADR_W'(1);
        end
        // The newest pixel is the bottom-right corner, so the centre is one up and one left.
        x_next_s  = COORD_W'(pix_col_s) - COORD_W'(1);
        y_next_s  = pix_row_s - COORD_W'(1);
    end

`ifdef SOBEL_BORDER_EN
    logic border_r;

    // Edge flag registered alongside win_valid from the same centre coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            border_r <= 1'b0;
        end else begin
            border_r <= win_s & on_edge(x_next_s, y_next_s, LINE_W, FRAME_H);
        end
    end

    assign bus.border = border_r;
`endif

    // Frame state sequencing and registration of every output for the accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= WAIT_SOF;
            wr_en_r      <= 3'b000;
            shift_en_r   <= 1'b0;
            wr_adr_r     <= {ADR_W{1'b0}};
            rd_adr_r     <= ADR_W'(1);
            win_valid_r  <= 1'b0;
            x_r          <= {COORD_W{1'b0}};
            y_r          <= {COORD_W{1'b0}};
            line_done_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (take_s) begin
                wr_en_r      <= {row_ge2_s, row_ge1_s, 1'b1};
                shift_en_r   <= 1'b1;
                wr_adr_r     <= pix_col_s;
                rd_adr_r     <= rd_next_s;
                win_valid_r  <= win_s;
                line_done_r  <= line_end_s;
                frame_done_r <= frame_end_s;
                if (win_s) begin
                    x_r <= x_next_s;
                    y_r <= y_next_s;
                end else begin
                    x_r <= x_r;
                    y_r <= y_r;
                end
            end else begin
                // Idle cycle: enables drop, addresses and coordinates hold.
                wr_en_r      <= 3'b000;
                shift_en_r   <= 1'b0;
                wr_adr_r     <= wr_adr_r;
                rd_adr_r     <= rd_adr_r;
                win_valid_r  <= 1'b0;
                line_done_r  <= 1'b0;
                frame_done_r <= 1'b0;
                x_r          <= x_r;
                y_r          <= y_r;
            end

            // A qualified sof restarts the frame from any state and outranks the done events.
            case (state_r)
                WAIT_SOF: begin
                    if (restart_s) begin
                        state_r <= PRIME;
                    end else begin
                        state_r <= WAIT_SOF;
                    end
                end
                PRIME: begin
                    if (restart_s) begin
                        state_r <= PRIME;
                    end else if (frame_end_s) begin
                        state_r <= WAIT_SOF;
                    end else if (line_end_s && (pix_row_s == COORD_W'(1))) begin
                        state_r <= STREAM;
                    end else begin
                        state_r <= PRIME;
                    end
                end
                STREAM: begin
                    if (restart_s) begin
                        state_r <= PRIME;
                    end else if (frame_end_s) begin
                        state_r <= WAIT_SOF;
                    end else begin
                        state_r <= STREAM;
                    end
                end
                default: begin
                    state_r <= WAIT_SOF;
                end
            endcase
        end
    end

    assign bus.wr_en      = wr_en_r;
    assign bus.shift_en   = shift_en_r;
    assign bus.wr_adr     = wr_adr_r;
    assign bus.rd_adr     = rd_adr_r;
    assign bus.win_valid  = win_valid_r;
    assign bus.x_out      = x_r;
    assign bus.y_out      = y_r;
    assign bus.line_done  = line_done_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: self-checking bench for sobel_window_ctrl with LINE_W=4, FRAME_H=4.
// The reference model tracks a pixel index within the frame and derives column/row
// with division and modulo. Build with SOBEL_BORDER_EN to also check the border flag.
module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int LW = 4;
    localparam int FH = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_window_ctrl_if #(.ADR_W(AW)) bus ();

    sobel_window_ctrl #(
        .LINE_W  (LW),
        .FRAME_H (FH),
        .ADR_W   (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state and expected outputs.
    bit                 m_active;
    int                 m_p;
    logic [7:0]         exp_ctrl;
    logic [AW-1:0]      exp_wr_adr;
    logic [AW-1:0]      exp_rd_adr;
    logic [COORD_W-1:0] exp_x;
    logic [COORD_W-1:0] exp_y;

    logic       act_border;
    logic [7:0] act_ctrl;
`ifdef SOBEL_BORDER_EN
    assign act_border = bus.border;
`else
    assign act_border = 1'b0;
`endif
    // {wr_en[2:0], shift_en, win_valid, line_done, frame_done, border}
    assign act_ctrl = {bus.wr_en, bus.shift_en, bus.win_valid, bus.line_done,
                       bus.frame_done, act_border};

    task automatic model_reset();
        m_active   = 1'b0;
        m_p        = 0;
        exp_ctrl   = 8'h00;
        exp_wr_adr = AW'(0);
        exp_rd_adr = AW'(1);
        exp_x      = COORD_W'(0);
        exp_y      = COORD_W'(0);
    endtask

    task automatic apply_reset(input bit v);
        @(negedge clk);
        rst           = 1'b1;
        bus.sof       = 1'($urandom_range(0, 1));
        bus.pix_valid = v;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Drive one clock of stimulus and compute what the outputs must show afterwards.
    task automatic cycle(input bit s, input bit v);
        int   c;
        int   r;
        bit   win;
        bit   ld;
        bit   fd;
        bit   bd;
        logic [2:0] we;
        @(negedge clk);
        rst           = 1'b0;
        bus.sof       = s;
        bus.pix_valid = v;
        exp_ctrl      = 8'h00;
        if (v && (s || m_active)) begin
            if (s) m_p = 0;
            c   = m_p % LW;
            r   = m_p / LW;
            we  = {(r >= 2), (r >= 1), 1'b1};
            win = (r >= 2) && (c >= 2);
            ld  = (c == LW - 1);
            fd  = (m_p == LW * FH - 1);
            bd  = 1'b0;
            exp_wr_adr = AW'(c);
            exp_rd_adr = AW'((c + 1) % LW);
            if (win) begin
                exp_x = COORD_W'(c - 1);
                exp_y = COORD_W'(r - 1);
`ifdef SOBEL_BORDER_EN
                bd = (c - 1 == 1) || (c - 1 == LW - 2) || (r - 1 == 1) || (r - 1 == FH - 2);
`endif
            end
            exp_ctrl = {we, 1'b1, win, ld, fd, bd};
            m_active = !fd;
            m_p      = fd ? 0 : m_p + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        apply_reset(1'b1);
        n_cmp++;
        if (act_ctrl !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want %b", act_ctrl, 8'h00);
        end
        n_cmp++;
        if ({bus.wr_adr, bus.rd_adr} !== {3'd0, 3'd1}) begin
            n_err++;
            $display("FAIL reset_adr got wr=%0d rd=%0d want wr=0 rd=1", bus.wr_adr, bus.rd_adr);
        end
        n_cmp++;
        if ({bus.x_out, bus.y_out} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_xy got %0d,%0d want 0,0", bus.x_out, bus.y_out);
        end
    endtask

    task automatic test_no_sof();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1);
            n_cmp++;
            if (act_ctrl !== 8'h00) begin
                n_err++;
                $display("FAIL no_sof i=%0d got %b want %b", i, act_ctrl, 8'h00);
            end
        end
    endtask

    task automatic test_frame();
        int n_win = 0;
        int n_ld = 0;
        int n_fd = 0;
        int first_wr2 = -1;
        int wx[$];
        int wy[$];
        int ex[4] = '{1, 2, 1, 2};
        int ey[4] = '{1, 1, 2, 2};
        for (int i = 0; i < 16; i++) begin
            cycle(i == 0, 1'b1);
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_err++;
                $display("FAIL frame_ctrl px=%0d got %b want %b", i, act_ctrl, exp_ctrl);
            end
            n_cmp++;
            if ({bus.x_out, bus.y_out} !== {exp_x, exp_y}) begin
                n_err++;
                $display("FAIL frame_xy px=%0d got %0d,%0d want %0d,%0d", i, bus.x_out, bus.y_out, exp_x, exp_y);
            end
            if (bus.win_valid === 1'b1) begin
                n_win++;
                wx.push_back(int'(bus.x_out));
                wy.push_back(int'(bus.y_out));
            end
            if (bus.line_done === 1'b1) n_ld++;
            if (bus.frame_done === 1'b1) n_fd++;
            if (bus.wr_en[2] === 1'b1 && first_wr2 < 0) first_wr2 = i;
        end
        n_cmp++;
        if (first_wr2 != 8) begin
            n_err++;
            $display("FAIL frame_first_wr2 got %0d want 8", first_wr2);
        end
        n_cmp++;
        if ({n_win, n_ld, n_fd} !== {32'd4, 32'd4, 32'd1}) begin
            n_err++;
            $display("FAIL frame_counts got win=%0d ld=%0d fd=%0d want 4 4 1", n_win, n_ld, n_fd);
        end
        for (int k = 0; k < 4 && k < wx.size(); k++) begin
            n_cmp++;
            if (wx[k] != ex[k] || wy[k] != ey[k]) begin
                n_err++;
                $display("FAIL frame_win%0d got (%0d,%0d) want (%0d,%0d)", k, wx[k], wy[k], ex[k], ey[k]);
            end
        end
    endtask

    task automatic test_addr();
        int erd[4] = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 1'b1);
            n_cmp++;
            if (int'(bus.wr_adr) != i || int'(bus.rd_adr) != erd[i]) begin
                n_err++;
                $display("FAIL addr col=%0d got wr=%0d rd=%0d want wr=%0d rd=%0d", i, bus.wr_adr, bus.rd_adr, i, erd[i]);
            end
        end
        for (int i = 4; i < 16; i++) cycle(1'b0, 1'b1);
    endtask

    task automatic test_toggle();
        int n_win = 0;
        int wx[$];
        int wy[$];
        int ex[4] = '{1, 2, 1, 2};
        int ey[4] = '{1, 1, 2, 2};
        for (int i = 0; i < 32; i++) begin
            cycle(i == 0, (i % 2) == 0);
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_err++;
                $display("FAIL toggle_ctrl cyc=%0d got %b want %b", i, act_ctrl, exp_ctrl);
            end
            if ((i % 2) == 1) begin
                n_cmp++;
                if ({bus.wr_en, bus.shift_en} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL toggle_idle cyc=%0d got %b want 0000", i, {bus.wr_en, bus.shift_en});
                end
            end
            if (bus.win_valid === 1'b1) begin
                n_win++;
                wx.push_back(int'(bus.x_out));
                wy.push_back(int'(bus.y_out));
            end
        end
        n_cmp++;
        if (n_win != 4) begin
            n_err++;
            $display("FAIL toggle_win_count got %0d want 4", n_win);
        end
        for (int k = 0; k < 4 && k < wx.size(); k++) begin
            n_cmp++;
            if (wx[k] != ex[k] || wy[k] != ey[k]) begin
                n_err++;
                $display("FAIL toggle_win%0d got (%0d,%0d) want (%0d,%0d)", k, wx[k], wy[k], ex[k], ey[k]);
            end
        end
    endtask

    task automatic test_restart();
        int first_win = -1;
        for (int i = 0; i < 9; i++) cycle(i == 0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            cycle(k == 0, 1'b1);
            n_cmp++;
            if (act_ctrl !== exp_ctrl || {bus.wr_adr, bus.rd_adr} !== {exp_wr_adr, exp_rd_adr}) begin
                n_err++;
                $display("FAIL restart k=%0d got %b wr=%0d rd=%0d want %b wr=%0d rd=%0d", k, act_ctrl,
                         bus.wr_adr, bus.rd_adr, exp_ctrl, exp_wr_adr, exp_rd_adr);
            end
            if (bus.win_valid === 1'b1 && first_win < 0) first_win = k;
        end
        n_cmp++;
        if (first_win != 10) begin
            n_err++;
            $display("FAIL restart_first_win got %0d want 10", first_win);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) cycle(i == 0, 1'b1);
        apply_reset(1'b1);
        n_cmp++;
        if (act_ctrl !== 8'h00 || {bus.wr_adr, bus.rd_adr} !== {3'd0, 3'd1}) begin
            n_err++;
            $display("FAIL reset_mid got %b wr=%0d rd=%0d want 00000000 wr=0 rd=1", act_ctrl, bus.wr_adr, bus.rd_adr);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            n_cmp++;
            if (act_ctrl !== 8'h00) begin
                n_err++;
                $display("FAIL reset_mid_ignore i=%0d got %b want 00000000", i, act_ctrl);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, 1'b1);
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_err++;
                $display("FAIL reset_mid_resume i=%0d got %b want %b", i, act_ctrl, exp_ctrl);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_fd = 0;
        int n_win = 0;
        for (int i = 0; i < 32; i++) begin
            cycle((i % 16) == 0, 1'b1);
            n_cmp++;
            if (act_ctrl !== exp_ctrl || {bus.x_out, bus.y_out} !== {exp_x, exp_y}) begin
                n_err++;
                $display("FAIL b2b px=%0d got %b (%0d,%0d) want %b (%0d,%0d)", i, act_ctrl,
                         bus.x_out, bus.y_out, exp_ctrl, exp_x, exp_y);
            end
            if (bus.frame_done === 1'b1) n_fd++;
            if (bus.win_valid === 1'b1) n_win++;
        end
        n_cmp++;
        if (n_fd != 2 || n_win != 8) begin
            n_err++;
            $display("FAIL b2b_counts got fd=%0d win=%0d want fd=2 win=8", n_fd, n_win);
        end
    endtask

    task automatic test_random();
        bit s;
        bit v;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 75);
            s = ($urandom_range(0, 99) < 6);
            cycle(s, v);
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_err++;
                $display("FAIL rand_ctrl i=%0d got %b want %b", i, act_ctrl, exp_ctrl);
            end
            n_cmp++;
            if ({bus.wr_adr, bus.rd_adr} !== {exp_wr_adr, exp_rd_adr}) begin
                n_err++;
                $display("FAIL rand_adr i=%0d got wr=%0d rd=%0d want wr=%0d rd=%0d", i,
                         bus.wr_adr, bus.rd_adr, exp_wr_adr, exp_rd_adr);
            end
            n_cmp++;
            if ({bus.x_out, bus.y_out} !== {exp_x, exp_y}) begin
                n_err++;
                $display("FAIL rand_xy i=%0d got %0d,%0d want %0d,%0d", i, bus.x_out, bus.y_out, exp_x, exp_y);
            end
        end
    endtask

    initial begin
        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        model_reset();
        test_reset();
        test_no_sof();
        test_frame();
        apply_reset(1'b0);
        test_addr();
        test_toggle();
        test_restart();
        test_reset_mid();
        apply_reset(1'b0);
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
